// File: rtl/prm_edge_mask_engine.sv
// prm_edge_mask_engine
// Programmable multi-edge obstacle mask engine for the PRM collision-table flow.
// Holds EDGES x TERMS loadable product terms {en, care, val}, accepts a
// quantised configuration word over valid/ready, scans one term slot per cycle
// across all edges in parallel, and returns one mask bit per edge.
// Optional feature macro: PRM_EDGE_EARLY_EXIT_EN -- leave SCAN as soon as every
// edge has hit, instead of always scanning all TERMS slots.
module prm_edge_mask_engine #(
  parameter int unsigned IN_W  = 15,
  parameter int unsigned TERMS = 32,
  parameter int unsigned EDGES = 8
) (
  input  logic                                      CLK,
  input  logic                                      RST_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [IN_W-1:0]                           in_cfg,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [EDGES-1:0]                          out_mask,
  input  logic                                      wr_en,
  input  logic [((EDGES > 1) ? $clog2(EDGES) : 1)-1:0] wr_edge,
  input  logic [$clog2(TERMS)-1:0]                  wr_idx,
  input  logic                                      wr_term_en,
  input  logic [IN_W-1:0]                           wr_care,
  input  logic [IN_W-1:0]                           wr_val,
  input  logic                                      clr_all,
  output logic                                      busy
);

  localparam int unsigned EW = (EDGES > 1) ? $clog2(EDGES) : 1;
  localparam int unsigned TW = $clog2(TERMS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Term tables: enable bits are reset, care/val contents are don't-care
  // until written, so they carry no reset.
  logic [TERMS-1:0] en_q   [EDGES];
  logic [IN_W-1:0]  care_q [EDGES][TERMS];
  logic [IN_W-1:0]  val_q  [EDGES][TERMS];

  logic [IN_W-1:0]  cfg_q;
  logic [TW-1:0]    k_q;
  logic [EDGES-1:0] hit_q;
  logic [EDGES-1:0] match;
  logic             last_term;
  logic             accept;
  logic             tbl_wr;
  logic             tbl_clr;

  assign last_term = (k_q == TW'(TERMS - 1));
  assign accept    = (state_q == IDLE) && in_valid;
  // Table updates are only honoured while idle; clear beats write.
  assign tbl_clr   = (state_q == IDLE) && clr_all;
  assign tbl_wr    = (state_q == IDLE) && wr_en && !clr_all;

  // Evaluate term slot k of every edge against the latched configuration.
  always_comb begin
    match = '0;
    for (int unsigned e = 0; e < EDGES; e++) begin
      match[e] = en_q[e][k_q] &&
                 (((cfg_q ^ val_q[e][k_q]) & care_q[e][k_q]) == '0);
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    out_mask  = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_d = SCAN;
        end
      end
      SCAN: begin
`ifdef PRM_EDGE_EARLY_EXIT_EN
        if (last_term || (&(hit_q | match))) begin
          state_d = DONE;
        end
`else
        if (last_term) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        out_valid = 1'b1;
        out_mask  = hit_q;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Query datapath: latch the configuration on accept, accumulate hits while scanning.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cfg_q <= '0;
      k_q   <= '0;
      hit_q <= '0;
    end else if (accept) begin
      cfg_q <= in_cfg;
      k_q   <= '0;
      hit_q <= '0;
    end else if (state_q == SCAN) begin
      hit_q <= hit_q | match;
      if (!last_term) begin
        k_q <= k_q + TW'(1);
      end
    end
  end

  // Term enable bits: cleared by reset or clr_all, written by wr_en.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      for (int unsigned e = 0; e < EDGES; e++) begin
        en_q[e] <= '0;
      end
    end else if (tbl_clr) begin
      for (int unsigned e = 0; e < EDGES; e++) begin
        en_q[e] <= '0;
      end
    end else if (tbl_wr) begin
      for (int unsigned e = 0; e < EDGES; e++) begin
        if (wr_edge == EW'(e)) begin
          en_q[e][wr_idx] <= wr_term_en;
        end
      end
    end
  end

  // Term care/polarity storage.
  always_ff @(posedge CLK) begin
    if (tbl_wr) begin
      for (int unsigned e = 0; e < EDGES; e++) begin
        if (wr_edge == EW'(e)) begin
          care_q[e][wr_idx] <= wr_care;
          val_q[e][wr_idx]  <= wr_val;
        end
      end
    end
  end

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// tb_prm_edge_mask_engine
// Self-checking bench for prm_edge_mask_engine: directed cases followed by
// randomised queries against a table-level reference model. Honours
// PRM_EDGE_EARLY_EXIT_EN in its latency expectation.
module tb_prm_edge_mask_engine;

  localparam int unsigned IN_W  = 15;
  localparam int unsigned TERMS = 32;
  localparam int unsigned EDGES = 8;

  logic              CLK = 1'b0;
  logic              RST_n;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_cfg;
  logic              out_valid;
  logic              out_ready;
  logic [EDGES-1:0]  out_mask;
  logic              wr_en;
  logic [2:0]        wr_edge;
  logic [4:0]        wr_idx;
  logic              wr_term_en;
  logic [IN_W-1:0]   wr_care;
  logic [IN_W-1:0]   wr_val;
  logic              clr_all;
  logic              busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference tables
  bit              m_en   [EDGES][TERMS];
  logic [IN_W-1:0] m_care [EDGES][TERMS];
  logic [IN_W-1:0] m_val  [EDGES][TERMS];

  prm_edge_mask_engine #(
    .IN_W  (IN_W),
    .TERMS (TERMS),
    .EDGES (EDGES)
  ) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cfg     (in_cfg),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mask   (out_mask),
    .wr_en      (wr_en),
    .wr_edge    (wr_edge),
    .wr_idx     (wr_idx),
    .wr_term_en (wr_term_en),
    .wr_care    (wr_care),
    .wr_val     (wr_val),
    .clr_all    (clr_all),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int e = 0; e < EDGES; e++)
      for (int k = 0; k < TERMS; k++)
        m_en[e][k] = 1'b0;
  endtask

  // Mask = OR over enabled matching terms; latency from accept to out_valid.
  task automatic model_eval(input logic [IN_W-1:0] cfg,
                            output logic [EDGES-1:0] mask, output int unsigned lat);
    bit done;
    mask = '0;
    lat  = TERMS + 1;
    done = 1'b0;
    for (int k = 0; k < TERMS; k++) begin
      for (int e = 0; e < EDGES; e++)
        if (m_en[e][k] && (((cfg ^ m_val[e][k]) & m_care[e][k]) == '0))
          mask[e] = 1'b1;
`ifdef PRM_EDGE_EARLY_EXIT_EN
      if (!done && (&mask)) begin
        lat  = k + 2;
        done = 1'b1;
      end
`endif
    end
  endtask

  task automatic write_term(input int e, input int idx, input bit en,
                            input logic [IN_W-1:0] care, input logic [IN_W-1:0] val);
    wr_en = 1'b1; wr_edge = 3'(e); wr_idx = 5'(idx);
    wr_term_en = en; wr_care = care; wr_val = val;
    @(negedge CLK);
    wr_en = 1'b0;
    m_en[e][idx] = en; m_care[e][idx] = care; m_val[e][idx] = val;
  endtask

  // One query. hold: cycles out_ready stays low after out_valid.
  // scan_wr: issue a (to-be-dropped) write to edge 0 slot 0 mid-scan.
  // rst_at: pulse reset at that scan cycle (0 = never).
  task automatic query(input logic [IN_W-1:0] cfg, input int unsigned hold,
                       input bit scan_wr, input int unsigned rst_at);
    logic [EDGES-1:0] exp_mask;
    int unsigned      exp_lat;
    int unsigned      cyc;
    bit               seen;
    model_eval(cfg, exp_mask, exp_lat);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_cfg = cfg;
    @(negedge CLK);
    in_valid = 1'b0;
    cyc = 1;
    check("in_ready_scan", in_ready, 0);
    while (!out_valid && cyc < 200) begin
      if (scan_wr && cyc == 5) begin
        wr_en = 1'b1; wr_edge = 3'd0; wr_idx = 5'd0;
        wr_term_en = 1'b0; wr_care = '0; wr_val = '0;
      end
      if (scan_wr && cyc == 6) wr_en = 1'b0;
      if (rst_at != 0 && cyc == rst_at) begin
        RST_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        @(negedge CLK);
        RST_n = 1'b1;
        model_clear();
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
          @(negedge CLK);
          if (out_valid) seen = 1'b1;
        end
        check("rst_no_result", seen, 0);
        return;
      end
      @(negedge CLK);
      cyc++;
    end
    wr_en = 1'b0;
    check("latency", cyc, exp_lat);
    check("out_mask", out_mask, exp_mask);
    if (hold > 0) begin
      repeat (hold) @(negedge CLK);
      check("held_valid", out_valid, 1);
      check("held_mask", out_mask, exp_mask);
      check("held_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    check("post_out_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
  endtask

  initial begin
    RST_n = 1'b0; in_valid = 1'b0; in_cfg = '0; out_ready = 1'b0;
    wr_en = 1'b0; wr_edge = '0; wr_idx = '0; wr_term_en = 1'b0;
    wr_care = '0; wr_val = '0; clr_all = 1'b0;
    model_clear();
    repeat (3) @(negedge CLK);
    check("reset_in_ready", in_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_mask", out_mask, 0);
    RST_n = 1'b1;
    @(negedge CLK);

    // Empty tables after reset.
    query(15'h7FFF, 0, 0, 0);

    // Full-care exact match on edge 0 slot 0.
    write_term(0, 0, 1, 15'h7FFF, 15'h4321);
    query(15'h4321, 0, 0, 0);
    check("edge0_hit", out_mask, 0);  // dropped after handshake
    query(15'h4320, 0, 0, 0);

    // Reset mid-scan aborts and clears the tables.
    query(15'h4321, 0, 0, 10);
    query(15'h4321, 0, 0, 0);

    // Last slot is evaluated; result held under back-pressure.
    write_term(0, 0, 1, 15'h7FFF, 15'h4321);
    write_term(3, 31, 1, 15'h0003, 15'h0002);
    query(15'h7FFE, 10, 0, 0);

    // Write during scan is dropped.
    query(15'h4321, 0, 1, 0);
    query(15'h4321, 0, 0, 0);

    // Always-match term on every edge.
    for (int e = 0; e < EDGES; e++) write_term(e, 1, 1, '0, '0);
    query(15'($urandom), 0, 0, 0);

    // clr_all wins over a simultaneous write.
    clr_all = 1'b1; wr_en = 1'b1; wr_edge = 3'd1; wr_idx = 5'd2;
    wr_term_en = 1'b1; wr_care = '0; wr_val = '0;
    @(negedge CLK);
    clr_all = 1'b0; wr_en = 1'b0;
    model_clear();
    query(15'h1234, 0, 0, 0);

    // Randomised tables and queries.
    for (int q = 0; q < 1000; q++) begin
      if (q % 250 == 0) begin
        clr_all = 1'b1;
        @(negedge CLK);
        clr_all = 1'b0;
        model_clear();
      end
      if (q % 50 == 0) begin
        for (int w = 0; w < 16; w++)
          write_term(int'($urandom_range(0, EDGES - 1)), int'($urandom_range(0, TERMS - 1)),
                     ($urandom_range(0, 3) != 0),
                     15'($urandom & $urandom & $urandom), 15'($urandom));
      end
      query(15'($urandom), $urandom_range(0, 2), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
